picosoc_timer: RTL and testbench



---
 rtl/picosoc_timer.sv | 174 +++++++++++++++++
 tb/tb_picosoc_timer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/picosoc_timer.sv
// rtl/picosoc_timer.sv - programmable countdown timer on the PicoRV32 iomem bus
module picosoc_timer #(
    parameter int unsigned CLOCK_SPEED_HZ = 50_000_000,
    parameter int          COUNTER_WIDTH  = 32,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    output logic        irq_o
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_COUNT    = 3'd1;
    localparam logic [2:0] A_RELOAD   = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_PRESCALE = 3'd4;
    localparam logic [2:0] A_INFO     = 3'd5;

    logic                      r_ready;
    logic [31:0]               r_rdata;
    logic                      r_irq;
    logic [2:0]                r_ctrl;
    logic [COUNTER_WIDTH-1:0]  r_count;
    logic [COUNTER_WIDTH-1:0]  r_reload;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_pcnt;
    logic                      r_expired;

    logic        w_xfer;
    logic        w_wr;
    logic [2:0]  w_idx;
    logic [31:0] w_mask;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_reload;
    logic        w_wr_prescale;
    logic        w_w1c;
    logic        w_en_rise;
    logic        w_tick;
    logic        w_expire;
    logic [31:0] w_rmux;
    logic [28:0] w_unused_addr;

    // Byte-lane merge of write data into the current register contents
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // A transfer is accepted only in a cycle where ready is low, giving the 2-cycle cadence
    assign w_xfer        = iomem_valid & ~r_ready;
    assign w_wr          = w_xfer & (|iomem_wstrb);
    assign w_idx         = iomem_addr[4:2];
    assign w_unused_addr = {iomem_addr[31:5], iomem_addr[1:0]};
    assign w_mask        = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                            {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

    // CTRL only has bits in byte 0, so other lanes leave it untouched
    assign w_wr_ctrl     = w_wr & (w_idx == A_CTRL) & iomem_wstrb[0];
    assign w_wr_count    = w_wr & (w_idx == A_COUNT);
    assign w_wr_reload   = w_wr & (w_idx == A_RELOAD);
    assign w_wr_prescale = w_wr & (w_idx == A_PRESCALE);
    assign w_w1c         = w_wr & (w_idx == A_STATUS) & iomem_wstrb[0] & iomem_wdata[0];
    assign w_en_rise     = w_wr_ctrl & iomem_wdata[0] & ~r_ctrl[0];

    assign w_tick        = r_ctrl[0] & (r_pcnt == r_prescale);
    assign w_expire      = w_tick & (r_count == '0);

    // Read mux; unmapped words read as zero
    always_comb begin
        w_rmux = 32'd0;
        case (w_idx)
            A_CTRL:     w_rmux = {29'd0, r_ctrl};
            A_COUNT:    w_rmux = 32'(r_count);
            A_RELOAD:   w_rmux = 32'(r_reload);
            A_STATUS:   w_rmux = {31'd0, r_expired};
            A_PRESCALE: w_rmux = 32'(r_prescale);
            A_INFO:     w_rmux = 32'(CLOCK_SPEED_HZ);
            default:    w_rmux = 32'd0;
        endcase
    end

    // Bus handshake: single-cycle ready pulse, rdata zero outside that pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= w_xfer;
            r_rdata <= w_xfer ? w_rmux : 32'd0;
        end
    end

    // CTRL: CPU write wins; a one-shot expiry otherwise clears EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= 3'd0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= iomem_wdata[2:0];
        end else if (w_expire && !r_ctrl[1]) begin
            r_ctrl[0] <= 1'b0;
        end
    end

    // RELOAD and PRESCALE are plain byte-writable registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reload   <= '0;
            r_prescale <= '0;
        end else begin
            if (w_wr_reload)
                r_reload <= COUNTER_WIDTH'(f_merge(32'(r_reload), iomem_wdata, w_mask));
            if (w_wr_prescale)
                r_prescale <= PRESCALE_WIDTH'(f_merge(32'(r_prescale), iomem_wdata, w_mask));
        end
    end

    // Prescaler: held at 0 while disabled, restarted when EN is switched on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (w_en_rise || !r_ctrl[0] || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESCALE_WIDTH'(1);
        end
    end

    // Countdown: a CPU write to COUNT drops any decrement/reload in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= COUNTER_WIDTH'(f_merge(32'(r_count), iomem_wdata, w_mask));
        end else if (w_tick) begin
            if (r_count != '0)
                r_count <= r_count - COUNTER_WIDTH'(1);
            else if (r_ctrl[1])
                r_count <= r_reload;
        end
    end

    // EXPIRED: a set in the same cycle as a W1C takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_w1c) begin
            r_expired <= 1'b0;
        end
    end

    // Level interrupt, one cycle behind EXPIRED & IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_expired & r_ctrl[2];
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_picosoc_timer.sv
// tb/tb_picosoc_timer.sv - directed self-checking bench for picosoc_timer
module tb_picosoc_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cyc_a    = 0;

    picosoc_timer dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .iomem_ready (iomem_ready),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ready was seen high
    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        logic got;
        got = 1'b0;
        r = 32'd0;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (iomem_ready) begin
                got = 1'b1;
                r = iomem_rdata;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        check_eq("bus_ready", {31'd0, got}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] unused_r;
        bus(a, d, 4'hF, unused_r);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 32'd0, 4'h0, r);
        check_eq(tag, r, exp);
    endtask

    task automatic wait_irq_rise(input string tag, input int exp_delta);
        for (int i = 0; i < 60 && !irq_o; i++) @(negedge clk);
        check_eq(tag, 32'(cyc - cyc_a), 32'(exp_delta));
    endtask

    logic [31:0] exp_words [8];
    logic        got_rdy;

    initial begin
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check_eq("rst_irq",   {31'd0, irq_o},       32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Byte strobes on RELOAD
        wr(32'h08, 32'hAABBCCDD);
        begin
            logic [31:0] unused_r;
            bus(32'h08, 32'h11223344, 4'b0101, unused_r);
        end
        rd_check("byte_strobe", 32'h08, 32'hAA22CC44);

        // Handshake: valid held 4 cycles -> ready 1,0,1,0
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h08;
        iomem_wstrb = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("hs_ready_c%0d", k), {31'd0, iomem_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check_eq($sformatf("hs_rdata_c%0d", k), iomem_rdata, (k % 2 == 1) ? 32'hAA22CC44 : 32'd0);
        end
        iomem_valid = 1'b0;

        // One-shot, PRESCALE=0, COUNT=2
        wr(32'h04, 32'd2);
        wr(32'h00, 32'b001);
        rd_check("oneshot_cnt1", 32'h04, 32'd1);
        rd_check("oneshot_cnt0", 32'h04, 32'd0);
        rd_check("oneshot_ctrl", 32'h00, 32'd0);
        rd_check("oneshot_exp",  32'h0C, 32'd1);
        rd_check("oneshot_hold", 32'h04, 32'd0);
        wr(32'h0C, 32'd1);
        rd_check("w1c_clear", 32'h0C, 32'd0);

        // Auto-reload, PRESCALE=3, RELOAD=4, COUNT=0
        wr(32'h10, 32'd3);
        wr(32'h08, 32'd4);
        wr(32'h04, 32'd0);
        wr(32'h00, 32'b111);
        cyc_a = cyc;
        check_eq("ar_irq_low", {31'd0, irq_o}, 32'd0);
        wait_irq_rise("ar_first_irq", 5);
        wr(32'h0C, 32'd1);
        check_eq("w1c_irq_lag", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        check_eq("w1c_irq_drop", {31'd0, irq_o}, 32'd0);
        wait_irq_rise("ar_second_irq", 25);
        wr(32'h0C, 32'd1);

        // W1C landing on the expiry edge (A+44)
        while (cyc < cyc_a + 43) @(negedge clk);
        wr(32'h0C, 32'd1);
        rd_check("coll_w1c_set_wins", 32'h0C, 32'd1);

        // COUNT write landing on a tick edge (A+52)
        while (cyc < cyc_a + 51) @(negedge clk);
        wr(32'h04, 32'h10);
        rd_check("coll_count_write", 32'h04, 32'h10);

        // Asynchronous reset while ready is high and the counter is running
        check_eq("pre_rst_irq", {31'd0, irq_o}, 32'd1);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h14;
        iomem_wstrb = 4'd0;
        got_rdy     = 1'b0;
        for (int i = 0; i < 4 && !got_rdy; i++) begin
            @(posedge clk);
            #1;
            got_rdy = iomem_ready;
        end
        check_eq("pre_rst_ready", {31'd0, got_rdy}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("async_rst_ready", {31'd0, iomem_ready}, 32'd0);
        check_eq("async_rst_rdata", iomem_rdata, 32'd0);
        check_eq("async_rst_irq",   {31'd0, irq_o}, 32'd0);
        iomem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Writes to INFO and an unmapped word are ignored
        wr(32'h14, 32'hFFFFFFFF);
        wr(32'h18, 32'hFFFFFFFF);
        exp_words = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd50_000_000, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++)
            rd_check($sformatf("post_rst_word%0d", i), 32'(i * 4), exp_words[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
